// File: rtl/mips_pkg.sv
// Shared types and constants for the execute-stage HI/LO unit.
package mips_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } hilo_state_t;

  localparam int unsigned DIV_ITERATIONS = 32;
  localparam int unsigned DIV_CNT_W      = $clog2(DIV_ITERATIONS) + 1;

  function automatic logic [31:0] negate32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to 2^31, which still fits unsigned.
  function automatic logic [31:0] magnitude32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? negate32(v) : v;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle over DIV_ITERATIONS cycles.
module serial_divider
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  logic [31:0]          r_quo;
  logic [31:0]          r_rem;
  logic [31:0]          r_div;
  logic [DIV_CNT_W-1:0] r_count;
  logic                 r_active;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;

  // w_shift < 2*divisor, so bit 32 of the difference is a clean borrow flag.
  always_comb begin
    w_shift = {r_rem, r_quo[31]};
    w_diff  = w_shift - {1'b0, r_div};
    w_fits  = ~w_diff[32];
  end

  // Asserted during the cycle whose closing edge performs the final step.
  assign o_done      = r_active && (r_count == DIV_CNT_W'(DIV_ITERATIONS - 1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_abort) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_quo    <= i_dividend;
      r_rem    <= '0;
      r_div    <= i_divisor;
      r_count  <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_quo   <= {r_quo[30:0], w_fits};
      r_rem   <= w_fits ? w_diff[31:0] : w_shift[31:0];
      r_count <= r_count + DIV_CNT_W'(1);
      if (o_done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_hilo_unit.sv
// Execute-stage HI/LO unit: single-cycle multiply and moves, iterative divide.
module execute_hilo_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  hilo_op_t    hilo_operation_execute,
  input  logic [31:0] source_A_execute,
  input  logic [31:0] source_B_execute,
  input  logic        flush_execute,
  output logic        hilo_busy_execute,
  output logic [31:0] ALU_HI_output_execute,
  output logic [31:0] ALU_LO_output_execute
);

  hilo_state_t r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic        w_is_div;
  logic        w_is_signed_div;
  logic        w_div_start;
  logic        w_div_abort;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_done;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  always_comb begin
    w_smul = $signed({{32{source_A_execute[31]}}, source_A_execute})
           * $signed({{32{source_B_execute[31]}}, source_B_execute});
    w_umul = {32'd0, source_A_execute} * {32'd0, source_B_execute};
    w_is_signed_div = (hilo_operation_execute == DIV);
    w_is_div        = w_is_signed_div || (hilo_operation_execute == DIVU);
    w_mag_a = magnitude32(source_A_execute, w_is_signed_div);
    w_mag_b = magnitude32(source_B_execute, w_is_signed_div);
    w_div_start = (r_state == IDLE) && !flush_execute && w_is_div
               && (source_B_execute != '0);
    w_div_abort = flush_execute && (r_state != IDLE);
  end

  serial_divider u_divider (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_abort     (w_div_abort),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!flush_execute) begin
            case (hilo_operation_execute)
              MULT:  {r_hi, r_lo} <= w_smul;
              MULTU: {r_hi, r_lo} <= w_umul;
              MTHI:  r_hi <= source_A_execute;
              MTLO:  r_lo <= source_A_execute;
              DIV, DIVU: begin
                // Division by zero is a no-op: no state change, no busy.
                if (source_B_execute != '0) begin
                  r_state <= DIVIDE;
                  r_busy  <= 1'b1;
                  r_neg_q <= w_is_signed_div && (source_A_execute[31] ^ source_B_execute[31]);
                  r_neg_r <= w_is_signed_div && source_A_execute[31];
                end
              end
              default: ;
            endcase
          end
        end
        DIVIDE: begin
          if (flush_execute) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_div_done) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          if (!flush_execute) begin
            r_lo <= r_neg_q ? negate32(w_quo) : w_quo;
            r_hi <= r_neg_r ? negate32(w_rem) : w_rem;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hilo_busy_execute     = r_busy;
  assign ALU_HI_output_execute = r_hi;
  assign ALU_LO_output_execute = r_lo;

endmodule

// File: tb/tb_execute_hilo_unit.sv
// Self-checking bench: behavioural HI/LO model plus directed and random stimulus.
module tb_execute_hilo_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        t_reset;
  hilo_op_t    t_op;
  logic [31:0] t_a;
  logic [31:0] t_b;
  logic        t_flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_hilo_unit dut (
    .clk                   (clk),
    .reset                 (t_reset),
    .hilo_operation_execute(t_op),
    .source_A_execute      (t_a),
    .source_B_execute      (t_b),
    .flush_execute         (t_flush),
    .hilo_busy_execute     (busy),
    .ALU_HI_output_execute (hi),
    .ALU_LO_output_execute (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a divide is "busy for 33 edges, then the result appears".
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left = 0;
  bit          m_live = 0;
  longint      sa, sb;
  logic [63:0] prod;

  always @(posedge clk) begin
    if (t_reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_live = 1;
    end else if (m_left > 0) begin
      if (t_flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (!t_flush) begin
      sa = longint'($signed(t_a));
      sb = longint'($signed(t_b));
      case (t_op)
        MULT:  begin prod = 64'(sa * sb); m_hi = prod[63:32]; m_lo = prod[31:0]; end
        MULTU: begin prod = {32'd0, t_a} * {32'd0, t_b}; m_hi = prod[63:32]; m_lo = prod[31:0]; end
        MTHI:  m_hi = t_a;
        MTLO:  m_lo = t_a;
        DIV:   if (t_b != 0) begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); m_left = 33; end
        DIVU:  if (t_b != 0) begin p_lo = t_a / t_b; p_hi = t_a % t_b; m_left = 33; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  task automatic do_op(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    t_op = op; t_a = a; t_b = b;
    @(negedge clk);
    t_op = NOP;
  endtask

  // Counts busy cycles seen at negedges, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 1;
    while (busy && n < 45) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  int nb;

  initial begin
    t_reset = 1'b1; t_op = NOP; t_a = '0; t_b = '0; t_flush = 1'b0;
    repeat (2) @(negedge clk);
    t_reset = 1'b0;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    do_op(MULT, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    chk("mult_busy", {31'd0, busy}, 32'd0);
    do_op(MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    do_op(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(nb);
    chk("div_busy_cycles", nb, 32'd33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    do_op(DIVU, 32'd100, 32'd7);
    wait_idle(nb);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    do_op(MTHI, 32'h1234_5678, 32'd0);
    do_op(MTLO, 32'h9ABC_DEF0, 32'd0);
    chk("mthi_rb", hi, 32'h1234_5678);
    chk("mtlo_rb", lo, 32'h9ABC_DEF0);
    do_op(DIVU, 32'd5, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("div0_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    chk("div0_hi", hi, 32'h1234_5678);
    chk("div0_lo", lo, 32'h9ABC_DEF0);

    do_op(MTHI, 32'hAAAA_0000, 32'd0);
    @(negedge clk);
    t_flush = 1'b1; t_op = MTHI; t_a = 32'h5555_5555;
    @(negedge clk);
    t_flush = 1'b0; t_op = NOP;
    chk("idle_flush_hi", hi, 32'hAAAA_0000);

    do_op(DIVU, 32'd1000, 32'd3);
    t_op = MTLO; t_a = 32'hDEAD_BEEF;
    repeat (8) @(negedge clk);
    t_flush = 1'b1; t_op = NOP;
    @(negedge clk);
    t_flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'hAAAA_0000);
    chk("flush_lo", lo, 32'h9ABC_DEF0);

    do_op(DIV, 32'd1000, 32'd7);
    repeat (18) @(negedge clk);
    t_reset = 1'b1;
    @(negedge clk);
    t_reset = 1'b0;
    chk("rst_div_hi", hi, 32'd0);
    chk("rst_div_lo", lo, 32'd0);
    chk("rst_div_busy", {31'd0, busy}, 32'd0);
    do_op(MTHI, 32'h0000_0077, 32'd0);
    @(negedge clk);
    t_reset = 1'b1; t_op = MULT; t_a = 32'd3; t_b = 32'd5;
    @(negedge clk);
    t_reset = 1'b0; t_op = NOP;
    chk("rst_mult_hi", hi, 32'd0);
    chk("rst_mult_lo", lo, 32'd0);

    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(nb);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    do_op(DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(nb);
    chk("neg_div_lo", lo, 32'hFFFF_FFFD);
    chk("neg_div_hi", hi, 32'd1);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      t_op = hilo_op_t'($urandom_range(0, 6));
      case ($urandom_range(0, 7))
        0:       t_a = 32'h8000_0000;
        1:       t_a = 32'hFFFF_FFFF;
        2:       t_a = $urandom_range(0, 20);
        default: t_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       t_b = 32'd0;
        1:       t_b = 32'hFFFF_FFFF;
        2:       t_b = $urandom_range(1, 9);
        default: t_b = $urandom;
      endcase
      t_flush = ($urandom_range(0, 39) == 0);
      t_reset = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk);
    t_op = NOP; t_flush = 1'b0; t_reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_hilo_unit.md
EXECUTE_HILO_UNIT -- requirements
Module: execute_hilo_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- hilo_operation_execute  in  3  hilo_op_t: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- source_A_execute  in  32  rs operand (dividend/multiplicand; MTHI/MTLO data).
- source_B_execute  in  32  rt operand (divisor/multiplier).
- flush_execute  in  1  squash current issue / abort divide in flight.
- hilo_busy_execute  out  1  stall request to hazard unit.
- ALU_HI_output_execute  out  32  current HI register.
- ALU_LO_output_execute  out  32  current LO register.

Function
REQ-003 The block SHALL have states IDLE, DIVIDE, FINISH; hilo_busy_execute SHALL be high exactly when the state is not IDLE.
REQ-004 In IDLE, an operation SHALL issue on a rising edge with flush_execute low; in DIVIDE/FINISH the operation input SHALL be ignored, and the hazard unit holds it.
REQ-005 MULT/MULTU SHALL write the 64-bit product, signed/unsigned respectively, to {HI,LO} at the issue edge (1-cycle latency, no busy).
REQ-006 MTHI/MTLO SHALL write source_A_execute to HI/LO at the issue edge; the other register is unchanged.
REQ-007 DIV/DIVU with nonzero divisor SHALL latch operands and go IDLE->DIVIDE with iteration counter 0.
REQ-008 DIVIDE SHALL perform one restoring-division step per cycle on magnitudes for 32 cycles, then go to FINISH.
REQ-009 FINISH SHALL apply signs and write LO=quotient, HI=remainder at its closing edge, then return to IDLE.
REQ-010 For a DIV issued at edge T, busy SHALL be high for 33 cycles, and new HI/LO SHALL be visible after edge T+33.
REQ-011 Signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-012 0x80000000 DIV 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-013 DIV/DIVU by zero SHALL leave HI/LO unchanged, stay IDLE and never assert busy.
REQ-014 flush_execute high in IDLE SHALL suppress issue.
REQ-015 flush_execute high in DIVIDE or FINISH SHALL return to IDLE at the next edge without writing HI/LO.
REQ-016 NOP SHALL change no state.
REQ-017 HI/LO outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-018 reset high at an edge SHALL set state=IDLE, HI=0, LO=0, counter=0 and busy=0, overriding any simultaneous issue or flush.
REQ-019 reset mid-divide SHALL abort with no HI/LO write; busy SHALL be low in the cycle after the reset edge.

Structure
REQ-020 hilo_op_t, the state enum and DIV_ITERATIONS=32 SHALL live in shared package mips_pkg.
REQ-021 The iterative datapath SHALL be a sub-module serial_divider (start, operands, done, quotient, remainder); multiply and HI/LO storage SHALL stay in the top module.

Verification
REQ-022 MULT 0xFFFFFFFF x 0x00000002 SHALL give HI=0xFFFFFFFF, LO=0xFFFFFFFE one edge later; MULTU with the same operands SHALL give HI=0x00000001, LO=0xFFFFFFFE.
REQ-023 DIV 0xFFFFFFF9 (-7) / 2 SHALL give busy for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 SHALL give LO=14, HI=2.
REQ-024 MTHI 0x12345678, then MTLO 0x9ABCDEF0, SHALL read back both values; a following DIVU 5/0 SHALL leave them unchanged with busy never asserted.
REQ-025 DIVU issued, then an MTLO presented during busy, SHALL ignore the MTLO; asserting flush at cycle 10 SHALL return to IDLE with HI/LO unchanged.
REQ-026 reset asserted at cycle 20 of a DIV SHALL give HI=LO=0 and busy low on the next cycle; reset coincident with a MULT issue SHALL give HI=LO=0.
REQ-027 0x80000000 DIV -1 and DIV 7/-2 SHALL give LO=0x80000000/HI=0 and LO=0xFFFFFFFD/HI=1 respectively.
